heap_array_reader: RTL and testbench

- Read-side counterpart to the heap array allocator/writer used by the BTree fpga test programs.
- Given an array handle, it reads the array's length from the array-size table, then streams each element out of heap memory over a valid/ready interface.
- When requested, it returns the handle to the freed-arrays stack after the last element is accepted.
- Sits between heap/size memories (synchronous read) and a consumer such as a test checker or output channel.

---
 rtl/heap_array_reader.sv | 178 +++++++++++++++++
 tb/tb_heap_array_reader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_array_reader.sv
// heap_array_reader
// Looks up an array's length in the size table, streams the array's elements
// out of heap memory over a valid/ready channel in index order, and can push
// the handle onto the freed-arrays stack once the last element is taken.
// Both memories have one cycle of read latency; all outputs are registered.
// Optional build macro: HEAP_READER_BOUNDS_EN rejects out-of-range handles and
// oversized lengths with a one-cycle error pulse. Without it, error stays 0.
module heap_array_reader #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 8,
    parameter int NArrays            = 4,
    parameter int NHeap              = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [MemoryElementWidth-1:0] req_array,
    input  logic                          req_free,
    output logic [MemoryElementWidth-1:0] size_addr,
    output logic                          size_rd,
    input  logic [MemoryElementWidth-1:0] size_rdata,
    output logic [MemoryElementWidth-1:0] heap_addr,
    output logic                          heap_rd,
    input  logic [MemoryElementWidth-1:0] heap_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MemoryElementWidth-1:0] out_data,
    output logic [MemoryElementWidth-1:0] out_index,
    output logic                          out_last,
    output logic                          free_valid,
    output logic [MemoryElementWidth-1:0] free_array,
    output logic                          busy,
    output logic                          error
);

    localparam int W = MemoryElementWidth;

    // The heap is laid out as NArrays areas of NArea words each.
    if (NHeap != NArrays * NArea) begin : g_bad_geometry
        $error("heap_array_reader: NHeap must equal NArrays*NArea");
    end

    typedef enum logic [2:0] {
        IDLE, SIZE_REQ, SIZE, READ, WAIT, EMIT, FREE
    } state_t;

    state_t         state, next_state;
    logic [W-1:0]   array_q;     // handle being read
    logic           free_q;      // free the handle when done
    logic [W-1:0]   len_q;       // element count from the size table
    logic [W-1:0]   index_q;     // index of the element in flight
    logic [W-1:0]   area_base;   // heap address of element 0
    logic           accept;
    logic           handshake;
    logic           bad_handle;
    logic           bad_len;

    assign accept    = req_valid && req_ready;
    assign handshake = out_valid && out_ready;
    assign area_base = array_q * W'(NArea);

`ifdef HEAP_READER_BOUNDS_EN
    assign bad_handle = (req_array >= W'(NArrays));
    assign bad_len    = (size_rdata > W'(NArea));
`else
    assign bad_handle = 1'b0;
    assign bad_len    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            IDLE:     if (accept) next_state = bad_handle ? IDLE : SIZE_REQ;
            SIZE_REQ: next_state = SIZE;
            SIZE: begin
                if (bad_len)                 next_state = IDLE;
                else if (size_rdata == '0)   next_state = free_q ? FREE : IDLE;
                else                         next_state = READ;
            end
            READ:     next_state = WAIT;
            WAIT:     next_state = EMIT;
            EMIT: begin
                if (handshake) begin
                    if (out_last) next_state = free_q ? FREE : IDLE;
                    else          next_state = READ;
                end
            end
            FREE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Registered outputs and datapath: strobes follow the state being entered,
    // captures happen on the edge that leaves the capturing state.
    always_ff @(posedge clock) begin
        // NOTE: every register here is reset, including the data registers,
        // because a reset must leave all outputs at 0 even mid-transfer.
        if (reset) begin
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            size_addr  <= '0;
            size_rd    <= 1'b0;
            heap_addr  <= '0;
            heap_rd    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            free_valid <= 1'b0;
            free_array <= '0;
            array_q    <= '0;
            free_q     <= 1'b0;
            len_q      <= '0;
            index_q    <= '0;
        end else begin
            req_ready  <= (next_state == IDLE);
            busy       <= (next_state != IDLE);
            size_rd    <= (next_state == SIZE_REQ);
            heap_rd    <= (next_state == READ);
            free_valid <= (state == FREE);
            case (state)
                IDLE: begin
                    if (accept && !bad_handle) begin
                        array_q   <= req_array;
                        free_q    <= req_free;
                        size_addr <= req_array;
                    end
                end
                SIZE: begin
                    len_q     <= size_rdata;
                    index_q   <= '0;
                    heap_addr <= area_base;
                end
                WAIT: begin
                    out_data  <= heap_rdata;
                    out_index <= index_q;
                    out_last  <= (index_q == len_q - W'(1));
                    out_valid <= 1'b1;
                end
                EMIT: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (!out_last) begin
                            index_q   <= index_q + W'(1);
                            heap_addr <= area_base + index_q + W'(1);
                        end
                    end
                end
                FREE:    free_array <= array_q;
                default: ;
            endcase
        end
    end

`ifdef HEAP_READER_BOUNDS_EN
    // One-cycle error pulse for a rejected handle or an oversized length.
    always_ff @(posedge clock) begin
        if (reset) error <= 1'b0;
        else       error <= (state == IDLE && accept && bad_handle) ||
                            (state == SIZE && bad_len);
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_heap_array_reader.sv
// Testbench for heap_array_reader: synchronous-read memory models, a
// transaction-level reference model fed at request acceptance, and a single
// per-cycle compare process. Directed cases pin the model with literal values;
// a randomized phase follows. HEAP_READER_BOUNDS_EN enables the rejection cases.
module tb_heap_array_reader;

    localparam int W     = 12;
    localparam int NAREA = 8;
    localparam int NARR  = 4;
    localparam int NHEAP = 32;

    typedef struct packed {
        logic [W-1:0] idx;
        logic [W-1:0] data;
        logic         last;
    } elem_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_valid, req_ready, req_free;
    logic [W-1:0] req_array;
    logic [W-1:0] size_addr, size_rdata, heap_addr, heap_rdata;
    logic         size_rd, heap_rd;
    logic         out_valid, out_ready, out_last;
    logic [W-1:0] out_data, out_index;
    logic         free_valid, busy, error;
    logic [W-1:0] free_array;

    heap_array_reader #(
        .MemoryElementWidth(W), .NArea(NAREA), .NArrays(NARR), .NHeap(NHEAP)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_array(req_array), .req_free(req_free),
        .size_addr(size_addr), .size_rd(size_rd), .size_rdata(size_rdata),
        .heap_addr(heap_addr), .heap_rd(heap_rd), .heap_rdata(heap_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .free_valid(free_valid), .free_array(free_array),
        .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    // Memories and bookkeeping
    logic [W-1:0] size_mem [NARR];
    logic [W-1:0] heap_mem [NHEAP];

    int n_checks = 0;
    int n_fail   = 0;

    elem_t        exp_q[$];
    logic [W-1:0] free_exp[$];
    int           err_pending = 0;

    logic [W-1:0] seen_data[$];
    logic [W-1:0] seen_index[$];
    logic         seen_last[$];
    logic [W-1:0] seen_free[$];
    int free_cnt = 0, err_cnt = 0, acc_cnt = 0, size_rd_cnt = 0, heap_rd_cnt = 0;

    logic mon_en     = 1'b0;
    logic rand_ready = 1'b0;
    logic         prev_valid = 1'b0, prev_hs = 1'b0, prev_last = 1'b0;
    logic [W-1:0] prev_data = '0, prev_index = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected transaction for an accepted request, straight from the tables.
    function automatic void model_request(input logic [W-1:0] arr, input logic fr);
        int    len;
        elem_t e;
`ifdef HEAP_READER_BOUNDS_EN
        if (int'(arr) >= NARR) begin err_pending++; return; end
`endif
        len = int'(size_mem[arr[1:0]]);
`ifdef HEAP_READER_BOUNDS_EN
        if (len > NAREA) begin err_pending++; return; end
`endif
        for (int i = 0; i < len; i++) begin
            e.idx  = W'(i);
            e.data = heap_mem[int'(arr) * NAREA + i];
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
        if (fr) free_exp.push_back(arr);
    endfunction

    function automatic void clear_seen();
        seen_data.delete(); seen_index.delete(); seen_last.delete(); seen_free.delete();
        free_cnt = 0; err_cnt = 0;
    endfunction

    // Synchronous-read memories; data is garbage in cycles not following a read.
    always @(posedge clock) begin
        if (size_rd && int'(size_addr) < NARR) size_rdata <= size_mem[size_addr[1:0]];
        else                                   size_rdata <= W'($urandom);
        if (heap_rd && int'(heap_addr) < NHEAP) heap_rdata <= heap_mem[heap_addr[4:0]];
        else                                    heap_rdata <= W'($urandom);
    end

    // Random consumer back-pressure.
    always @(posedge clock) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Per-cycle compare process, sampled on the falling edge.
    always @(negedge clock) begin
        elem_t        e;
        logic [W-1:0] fa;
        if (!mon_en) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check("valid_held_until_ready", out_valid, 1);
                check("data_stable", out_data, prev_data);
                check("index_stable", out_index, prev_index);
                check("last_stable", out_last, prev_last);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) check("no_spurious_out_valid", out_valid, 0);
                else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("out_index", out_index, e.idx);
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                    seen_data.push_back(out_data);
                    seen_index.push_back(out_index);
                    seen_last.push_back(out_last);
                end
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
            prev_data  = out_data;
            prev_index = out_index;
            prev_last  = out_last;
            if (free_valid) begin
                free_cnt++;
                seen_free.push_back(free_array);
                if (free_exp.size() == 0) check("no_spurious_free", free_valid, 0);
                else begin
                    fa = free_exp.pop_front();
                    check("free_array", free_array, fa);
                end
            end
            if (error) begin
                err_cnt++;
                if (err_pending == 0) check("no_spurious_error", error, 0);
                else err_pending--;
            end
            if (size_rd) size_rd_cnt++;
            if (heap_rd) heap_rd_cnt++;
            if (req_valid && req_ready) begin
                acc_cnt++;
                check("accept_only_after_previous_done", exp_q.size() + free_exp.size(), 0);
                check("accept_not_busy", busy, 0);
                model_request(req_array, req_free);
            end
        end
    end

    // Present a request from posedge+1 and return just after the acceptance edge.
    task automatic issue(input logic [W-1:0] arr, input logic fr);
        int ok = 0;
        req_valid = 1'b1; req_array = arr; req_free = fr;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (req_ready) begin ok = 1; break; end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("request_accepted", ok, 1);
    endtask

    // Wait until the model has nothing outstanding and the block is idle.
    task automatic wait_idle(input string name);
        int done = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clock); #1;
            if (exp_q.size() == 0 && free_exp.size() == 0 && err_pending == 0 &&
                req_ready && !busy) begin
                done = 1; break;
            end
        end
        check(name, done, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hit, base;
        reset = 1'b1; req_valid = 1'b0; req_array = '0; req_free = 1'b0; out_ready = 1'b1;
        for (int a = 0; a < NARR; a++) size_mem[a] = '0;
        for (int h = 0; h < NHEAP; h++) heap_mem[h] = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_req_ready", req_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_outputs_zero", |{size_addr, size_rd, heap_addr, heap_rd, out_valid,
              out_data, out_index, out_last, free_valid, free_array, error}, 0);
        @(posedge clock); #1;
        reset = 1'b0; mon_en = 1'b1;
        @(posedge clock); #1;
        check("req_ready_in_idle", req_ready, 1);
        check("idle_not_busy", busy, 0);

        // Array 1, length 3, no free, consumer always ready
        size_mem[1] = 12'd3; heap_mem[8] = 12'd7; heap_mem[9] = 12'd0; heap_mem[10] = 12'd5;
        clear_seen();
        issue(12'd1, 1'b0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (out_valid) begin lat = k; break; end
        end
        check("first_out_latency", lat, 4);
        wait_idle("t1_completes");
        check("t1_count", seen_data.size(), 3);
        check("t1_data0", seen_data[0], 7);
        check("t1_data1", seen_data[1], 0);
        check("t1_data2", seen_data[2], 5);
        check("t1_index2", seen_index[2], 2);
        check("t1_last_pattern", {seen_last[0], seen_last[1], seen_last[2]}, 3'b001);
        check("t1_no_free", free_cnt, 0);

        // Same request with free, consumer stalls on element 1
        clear_seen();
        issue(12'd1, 1'b1);
        hit = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (out_valid && out_index == 12'd1) begin out_ready = 1'b0; hit = 1; break; end
        end
        check("t2_reached_elem1", hit, 1);
        repeat (5) begin
            @(posedge clock); #1;
            check("t2_stall_valid", out_valid, 1);
            check("t2_stall_index", out_index, 1);
            check("t2_stall_data", out_data, 0);
        end
        out_ready = 1'b1;
        wait_idle("t2_completes");
        check("t2_count", seen_data.size(), 3);
        check("t2_free_pulses", free_cnt, 1);
        check("t2_free_array", seen_free[0], 1);
        check("t2_ready_after_free", req_ready, 1);

        // Empty array 2 with free
        size_mem[2] = 12'd0;
        clear_seen();
        issue(12'd2, 1'b1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (free_valid) begin lat = k; break; end
        end
        check("empty_free_latency", lat, 3);
        wait_idle("t3_completes");
        check("t3_no_elements", seen_data.size(), 0);
        check("t3_free_pulses", free_cnt, 1);
        check("t3_free_array", seen_free[0], 2);

`ifdef HEAP_READER_BOUNDS_EN
        // Bad handle
        clear_seen();
        base = size_rd_cnt;
        issue(12'd4, 1'b1);
        check("bad_handle_error", error, 1);
        check("bad_handle_no_size_rd", size_rd, 0);
        @(posedge clock); #1;
        check("error_one_cycle", error, 0);
        check("bad_handle_stays_idle", req_ready, 1);
        wait_idle("t4a_completes");
        check("bad_handle_size_reads", size_rd_cnt - base, 0);
        check("bad_handle_no_free", free_cnt, 0);
        check("bad_handle_error_count", err_cnt, 1);

        // Oversized length
        size_mem[0] = 12'd9;
        clear_seen();
        base = heap_rd_cnt;
        issue(12'd0, 1'b1);
        wait_idle("t4b_completes");
        check("bad_len_heap_reads", heap_rd_cnt - base, 0);
        check("bad_len_error_count", err_cnt, 1);
        check("bad_len_no_free", free_cnt, 0);
        check("bad_len_no_elements", seen_data.size(), 0);
        size_mem[0] = 12'd0;
`endif

        // Reset while an element is waiting in EMIT
        size_mem[3] = 12'd5;
        for (int i = 0; i < 5; i++) heap_mem[24 + i] = W'($urandom);
        out_ready = 1'b0;
        issue(12'd3, 1'b1);
        hit = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (out_valid) begin hit = 1; break; end
        end
        check("t5_reached_emit", hit, 1);
        reset = 1'b1; mon_en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_outputs_zero", |{req_ready, size_addr, size_rd, heap_addr, heap_rd,
              out_data, out_index, out_last, free_valid, free_array, error}, 0);
        exp_q.delete(); free_exp.delete(); err_pending = 0;
        @(posedge clock); #1;
        reset = 1'b0; out_ready = 1'b1; mon_en = 1'b1;
        clear_seen();
        repeat (8) @(posedge clock);
        #1;
        check("midreset_no_free", free_cnt, 0);
        issue(12'd3, 1'b0);
        wait_idle("t5_completes");
        check("t5_count", seen_data.size(), 5);
        check("t5_last_index", seen_index[4], 4);

        // req_valid held high across whole transfers of array 3
        size_mem[3] = 12'd2;
        clear_seen();
        base = acc_cnt;
        req_array = 12'd3; req_free = 1'b0; req_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock); #1;
            if (acc_cnt - base >= 3) break;
        end
        req_valid = 1'b0;
        check("held_accepts", acc_cnt - base, 3);
        wait_idle("t6_completes");
        check("held_count", seen_data.size(), 6);
        check("held_index_restart", {seen_index[2], seen_index[3]}, {12'd0, 12'd1});

        // Randomized phase
        rand_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int gap;
            for (int a = 0; a < NARR; a++) begin
`ifdef HEAP_READER_BOUNDS_EN
                size_mem[a] = W'($urandom_range(0, NAREA + 3));
`else
                size_mem[a] = W'($urandom_range(0, NAREA));
`endif
            end
            for (int h = 0; h < NHEAP; h++) heap_mem[h] = W'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clock); #1; end
`ifdef HEAP_READER_BOUNDS_EN
            issue(W'($urandom_range(0, NARR + 1)), 1'($urandom_range(0, 1)));
`else
            issue(W'($urandom_range(0, NARR - 1)), 1'($urandom_range(0, 1)));
`endif
            wait_idle("random_completes");
        end
        rand_ready = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;

        check("final_model_drained", exp_q.size() + free_exp.size() + err_pending, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
